mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares a single OBI-style memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). It performs round-robin arbitration with address-phase locking and tracks up to MAX_OUTSTANDING accepted requests. In-order responses are routed back to the originating requester through an internal route FIFO. It sits between the core (IFU, LSU) and the memory interconnect, and adds no cycle of latency on either the request or the response path.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width; byte-enable width is DATA_WIDTH/8
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests (>=1)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
ifu_req  in  1  IFU request
ifu_addr  in  ADDR_WIDTH  IFU fetch address
ifu_gnt  out  1  IFU request accepted this cycle
ifu_rvalid  out  1  IFU response valid
ifu_rdata  out  DATA_WIDTH  IFU response data
lsu_req  in  1  LSU request
lsu_addr  in  ADDR_WIDTH  LSU address
lsu_we  in  1  LSU write enable
lsu_be  in  DATA_WIDTH/8  LSU byte enables
lsu_wdata  in  DATA_WIDTH  LSU write data
lsu_gnt  out  1  LSU request accepted this cycle
lsu_rvalid  out  1  LSU response valid (loads and stores)
lsu_rdata  out  DATA_WIDTH  LSU response data
mem_req  out  1  memory request
mem_addr  out  ADDR_WIDTH  selected address
mem_we  out  1  selected write enable (0 for IFU)
mem_be  out  DATA_WIDTH/8  selected byte enables (all ones for IFU)
mem_wdata  out  DATA_WIDTH  selected write data (0 for IFU)
mem_gnt  in  1  memory accepted request
mem_rvalid  in  1  memory response valid (in order)
mem_rdata  in  DATA_WIDTH  memory response data
arb_err  out  1  sticky protocol error flag

Behaviour:
- Reset (rst=1 at a clock edge): state ARB_IDLE, last_grant=IFU, outstanding count 0, route FIFO empty, arb_err=0. Reset applies mid-transaction as well; responses in flight are dropped, and the memory side is reset with the core.
- While rst=1: mem_req, ifu_gnt, lsu_gnt, ifu_rvalid and lsu_rvalid are forced to 0.
- Handshake: a request is accepted in the cycle with mem_req && mem_gnt. The selected master's gnt = mem_gnt && mem_req (combinational). The non-selected master's gnt = 0.
- A requester must hold req and its payload stable until its gnt is seen.
- Capacity gate: full = (count == MAX_OUTSTANDING). While full, mem_req=0 and both gnts=0.
- FSM ARB_IDLE: selection rule.
  - Only one master requesting: select it.
  - Both requesting: select the master not equal to last_grant. After reset this means the LSU wins the first tie.
  - mem_req = (ifu_req || lsu_req) && !full.
  - If mem_req && !mem_gnt: latch the selection and go to ARB_LOCKED.
  - If mem_req && mem_gnt: update last_grant and push the master ID into the route FIFO; stay in ARB_IDLE.
- FSM ARB_LOCKED: the latched master stays selected regardless of the other master's req, and mem_req=1 (the capacity gate cannot close here, because the count only falls while locked).
  - On mem_gnt: update last_grant, push, return to ARB_IDLE.
- Responses: on mem_rvalid, pop the FIFO head and drive rvalid/rdata to that master in the same cycle. The other master's rvalid=0.
  - rdata to both masters = mem_rdata, unconditionally.
- Counter: count += accept, -= mem_rvalid. A simultaneous accept and response leaves count unchanged (FIFO push and pop in the same cycle). Count never exceeds MAX_OUTSTANDING.
- Error: mem_rvalid while the FIFO is empty sets arb_err=1 until reset. That response is not routed (both rvalids 0) and count stays 0.
- A master may issue back-to-back requests in consecutive cycles.

Decomposition:
- core_pkg additions: arb_master_t enum {ARB_MASTER_IFU, ARB_MASTER_LSU}; arb_state_t enum {ARB_IDLE, ARB_LOCKED}.
- Sub-module arb_route_fifo: synchronous FIFO of arb_master_t, depth MAX_OUTSTANDING.
  - Ports: push, pop, push_data, head, empty, full, count.
  - Supports simultaneous push/pop when full or empty-with-push as a pass-through write (no bypass needed, since pop follows push by at least one cycle).

Test Plan:
- IFU only: ifu_req=1 at 0x100, mem_gnt=1 -> ifu_gnt=1 same cycle, mem_addr=0x100, mem_be=4'hF. mem_rvalid 2 cycles later with 0xDEADBEEF -> ifu_rvalid=1, ifu_rdata=0xDEADBEEF, lsu_rvalid=0.
- Tie after reset, both req held, mem_gnt=1 every cycle -> grant order LSU, IFU, LSU, IFU. Responses routed in the same order.
- Lock: LSU selected, mem_gnt=0 for 3 cycles while ifu_req rises -> mem_addr stays lsu_addr, ifu_gnt=0. Then mem_gnt=1 -> lsu_gnt=1, and IFU is granted next cycle.
- Capacity (MAX_OUTSTANDING=2): two accepts with no rvalid -> mem_req=0 on the third cycle despite ifu_req=1. One mem_rvalid -> mem_req=1 the next cycle. Simultaneous accept and rvalid at count=1 -> count stays 1.
- Spurious response: mem_rvalid=1 with empty FIFO -> arb_err=1 and held, both rvalids 0.
- Reset mid-operation: rst=1 while ARB_LOCKED with count=2 -> next cycle state ARB_IDLE, count 0, arb_err 0. A tie then goes to the LSU first.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and helpers for the IFU/LSU memory arbiter
package mem_arbiter_pkg;

    typedef enum logic {ARB_MASTER_IFU, ARB_MASTER_LSU} arb_master_t;
    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    function automatic arb_master_t arb_other(input arb_master_t m);
        return m == ARB_MASTER_IFU ? ARB_MASTER_LSU : ARB_MASTER_IFU;
    endfunction

endpackage

// File: rtl/mem_arbiter_route_fifo.sv
// arb_route_fifo: in-order FIFO of master IDs for accepted, unanswered requests
module arb_route_fifo
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  arb_master_t   push_data,
    output arb_master_t   head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    arb_master_t     slots [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = slots[rd_ptr];
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);

    // storage write; contents are don't-care until pushed, so no reset
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_data;
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop) rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IFU/LSU arbiter onto one OBI-style memory port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ifu_req,
    input  logic [ADDR_WIDTH-1:0]   ifu_addr,
    output logic                    ifu_gnt,
    output logic                    ifu_rvalid,
    output logic [DATA_WIDTH-1:0]   ifu_rdata,
    input  logic                    lsu_req,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr,
    input  logic                    lsu_we,
    input  logic [DATA_WIDTH/8-1:0] lsu_be,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata,
    output logic                    lsu_gnt,
    output logic                    lsu_rvalid,
    output logic [DATA_WIDTH-1:0]   lsu_rdata,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    arb_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t    state, state_d;
    arb_master_t   last_grant, lock_master, sel;
    arb_master_t   route_head;
    logic          route_empty, route_full;
    logic [CW-1:0] route_count;
    logic          full, accept, pop;

    assign full = route_count == CW'(MAX_OUTSTANDING);

    arb_route_fifo #(.DEPTH(MAX_OUTSTANDING)) u_route (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .pop       (pop),
        .push_data (sel),
        .head      (route_head),
        .empty     (route_empty),
        .full      (route_full),
        .count     (route_count)
    );

    // selection, address-phase muxing, response routing and next state
    always_comb begin
        sel = state == ARB_LOCKED ? lock_master :
              (ifu_req && lsu_req) ? arb_other(last_grant) :
              lsu_req ? ARB_MASTER_LSU : ARB_MASTER_IFU;
        mem_req    = !rst && (state == ARB_LOCKED || ((ifu_req || lsu_req) && !full));
        accept     = mem_req && mem_gnt;
        ifu_gnt    = accept && sel == ARB_MASTER_IFU;
        lsu_gnt    = accept && sel == ARB_MASTER_LSU;
        mem_addr   = sel == ARB_MASTER_LSU ? lsu_addr : ifu_addr;
        mem_we     = sel == ARB_MASTER_LSU && lsu_we;
        mem_be     = sel == ARB_MASTER_LSU ? lsu_be : '1;
        mem_wdata  = sel == ARB_MASTER_LSU ? lsu_wdata : '0;
        pop        = !rst && mem_rvalid && !route_empty;
        ifu_rvalid = pop && route_head == ARB_MASTER_IFU;
        lsu_rvalid = pop && route_head == ARB_MASTER_LSU;
        ifu_rdata  = mem_rdata;
        lsu_rdata  = mem_rdata;
        state_d    = state == ARB_IDLE ? ((mem_req && !mem_gnt) ? ARB_LOCKED : ARB_IDLE) :
                     (mem_gnt ? ARB_IDLE : ARB_LOCKED);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ARB_IDLE;
        else state <= state_d;
    end

    // round-robin history, locked master and sticky spurious-response flag
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= ARB_MASTER_IFU;
            lock_master <= ARB_MASTER_IFU;
            arb_err     <= 1'b0;
        end else begin
            if (accept) last_grant <= sel;
            if (state == ARB_IDLE) lock_master <= sel;
            if (mem_rvalid && route_empty) arb_err <= 1'b1;
        end
    end

    // the capacity gate must keep every accept away from a full route FIFO
    a_no_accept_when_full: assert property (@(posedge clk) disable iff (rst) !(accept && route_full));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized check of mem_arbiter against a queue-based reference model
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAX = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req, lsu_req, lsu_we, mem_gnt, mem_rvalid;
    logic [AW-1:0] ifu_addr, lsu_addr;
    logic [3:0]    lsu_be;
    logic [DW-1:0] lsu_wdata, mem_rdata;
    logic          ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid, mem_req, mem_we, arb_err;
    logic [DW-1:0] ifu_rdata, lsu_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_we(lsu_we), .lsu_be(lsu_be),
        .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: masters are 0 = IFU, 1 = LSU
    bit route_q[$];
    bit last_m, locked, lock_m, err_m;

    // requester-side stimulus state (held until granted)
    bit            ifu_pend, lsu_pend;
    logic [AW-1:0] ia, la;
    logic          lwe;
    logic [3:0]    lbe;
    logic [DW-1:0] lwd;

    initial begin
        bit e_req, e_sel, e_acc, both;
        int pg, pr;
        {ifu_req, lsu_req, lsu_we, mem_gnt, mem_rvalid} = '0;
        {ifu_addr, lsu_addr, lsu_be, lsu_wdata, mem_rdata} = '0;
        rst = 1'b1;
        last_m = 0; locked = 0; lock_m = 0; err_m = 0;
        ifu_pend = 0; lsu_pend = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            pg = (cyc / 400) % 3 == 0 ? 85 : (cyc / 400) % 3 == 1 ? 25 : 55;
            pr = (cyc / 400) % 3 == 0 ? 60 : (cyc / 400) % 3 == 1 ? 15 : 40;
            rst = (cyc < 2) || ($urandom_range(0, 199) == 0);
            if (rst) begin
                ifu_pend = 0;
                lsu_pend = 0;
            end
            if (!ifu_pend && $urandom_range(0, 99) < 60) begin
                ifu_pend = 1;
                ia = $urandom;
            end
            if (!lsu_pend && $urandom_range(0, 99) < 60) begin
                lsu_pend = 1;
                la = $urandom; lwe = 1'($urandom); lbe = 4'($urandom); lwd = $urandom;
            end
            ifu_req = ifu_pend; ifu_addr = ia;
            lsu_req = lsu_pend; lsu_addr = la; lsu_we = lwe; lsu_be = lbe; lsu_wdata = lwd;
            mem_gnt    = $urandom_range(0, 99) < pg;
            mem_rvalid = route_q.size() > 0 ? $urandom_range(0, 99) < pr : $urandom_range(0, 99) < 2;
            mem_rdata  = $urandom;
            // expected behaviour from the arbitration rules
            both  = ifu_req && lsu_req;
            e_sel = locked ? lock_m : both ? !last_m : lsu_req;
            e_req = !rst && (locked || ((ifu_req || lsu_req) && route_q.size() < MAX));
            e_acc = e_req && mem_gnt;
            #1;
            check("mem_req", mem_req, e_req);
            check("ifu_gnt", ifu_gnt, e_acc && !e_sel);
            check("lsu_gnt", lsu_gnt, e_acc && e_sel);
            check("ifu_rvalid", ifu_rvalid, !rst && mem_rvalid && route_q.size() > 0 && !route_q[0]);
            check("lsu_rvalid", lsu_rvalid, !rst && mem_rvalid && route_q.size() > 0 && route_q[0]);
            check("ifu_rdata", ifu_rdata, mem_rdata);
            check("lsu_rdata", lsu_rdata, mem_rdata);
            check("arb_err", arb_err, err_m);
            if (e_req) begin
                check("mem_addr", mem_addr, e_sel ? la : ia);
                check("mem_we", mem_we, e_sel ? lwe : 1'b0);
                check("mem_be", mem_be, e_sel ? lbe : 4'hF);
                check("mem_wdata", mem_wdata, e_sel ? lwd : 32'h0);
            end
            @(posedge clk);
            if (rst) begin
                route_q.delete();
                last_m = 0; locked = 0; err_m = 0;
            end else begin
                if (mem_rvalid) begin
                    if (route_q.size() > 0) void'(route_q.pop_front());
                    else err_m = 1;
                end
                if (e_acc) begin
                    route_q.push_back(e_sel);
                    last_m = e_sel;
                    if (e_sel) lsu_pend = 0;
                    else ifu_pend = 0;
                end
                if (locked) begin
                    if (mem_gnt) locked = 0;
                end else if (e_req && !mem_gnt) begin
                    locked = 1;
                    lock_m = e_sel;
                end
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
